// File: rtl/dut_ctrl_param_if.sv
// Host-side operation interface of the DUT wrapper controller: request/commit
// handshake, abort and scan controls, and the datapath register controls.
interface dut_ctrl_param_if #(
    parameter int unsigned CNT_W = 8
) ();
    logic             val_op;
    logic             op_ack;
    logic             op_commit;
    logic             commit_ack;
    logic             abort;
    logic             sen;
    logic [CNT_W-1:0] calc_len;
    logic             reg_en;
    logic             reg_sel;
    logic [CNT_W-1:0] calc_cnt;
    logic             busy;
    logic             err_timeout;
    logic [CNT_W-1:0] done_cnt;

    // Host / environment side
    modport master (
        output val_op, commit_ack, abort, sen, calc_len,
        input  op_ack, op_commit, reg_en, reg_sel, calc_cnt, busy, err_timeout, done_cnt
    );

    // Controller side
    modport slave (
        input  val_op, commit_ack, abort, sen, calc_len,
        output op_ack, op_commit, reg_en, reg_sel, calc_cnt, busy, err_timeout, done_cnt
    );
endinterface

// File: rtl/dut_ctrl_param.sv
// Operation controller for the DUT wrapper: IDLE -> START -> CALC (len_q cycles)
// -> FINISH (wait for commit_ack, optional timeout). Freezes on scan enable,
// supports synchronous abort and counts committed operations.
module dut_ctrl_param #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned DEF_LEN = 8,
    parameter int unsigned TIMEOUT = 0
) (
    input logic              clk,
    input logic              reset,
    dut_ctrl_param_if.slave  bus
);

    // Wait counter only needs to reach TIMEOUT-1; keep one bit when disabled.
    localparam int unsigned WaitW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StCalc,
        StFinish
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [CNT_W-1:0] done_q, done_d;
    logic             err_q, err_d;

    logic abort_act;
    logic calc_last;

    // Abort only matters once an operation is in flight.
    assign abort_act = bus.abort && (state_q != StIdle);
    assign calc_last = (cnt_q == len_q - CNT_W'(1));

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            len_q   <= CNT_W'(DEF_LEN);
            wait_q  <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            wait_q  <= wait_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: abort beats scan freeze, which beats normal sequencing
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        wait_d  = wait_q;
        done_d  = done_q;
        err_d   = err_q;
        if (abort_act) begin
            state_d = StIdle;
            cnt_d   = '0;
            wait_d  = '0;
        end else if (!bus.sen) begin
            unique case (state_q)
                StIdle: begin
                    cnt_d = '0;
                    if (bus.val_op) begin
                        state_d = StStart;
                    end
                end
                StStart: begin
                    // A zero length request falls back to the default length.
                    len_d   = (bus.calc_len == '0) ? CNT_W'(DEF_LEN) : bus.calc_len;
                    state_d = StCalc;
                end
                StCalc: begin
                    if (calc_last) begin
                        cnt_d   = '0;
                        wait_d  = '0;
                        state_d = StFinish;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StFinish: begin
                    // An ack on the last timeout cycle still commits.
                    if (bus.commit_ack) begin
                        state_d = StIdle;
                        done_d  = done_q + CNT_W'(1);
                        wait_d  = '0;
                    end else if (TIMEOUT != 0) begin
                        if (wait_q == WaitLast) begin
                            state_d = StIdle;
                            err_d   = 1'b1;
                            wait_d  = '0;
                        end else begin
                            wait_d = wait_q + WaitW'(1);
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Output decode from the current state, then abort/scan gating
    always_comb begin
        bus.op_ack    = 1'b0;
        bus.op_commit = 1'b0;
        bus.reg_en    = 1'b0;
        bus.reg_sel   = 1'b1;
        unique case (state_q)
            StIdle:   ;
            StStart: begin
                bus.op_ack = 1'b1;
                bus.reg_en = 1'b1;
            end
            StCalc: begin
                bus.reg_en  = 1'b1;
                bus.reg_sel = 1'b0;
            end
            StFinish: bus.op_commit = 1'b1;
            default:  ;
        endcase
        if (abort_act) begin
            bus.reg_en = 1'b0;
        end else if (bus.sen) begin
            bus.reg_en    = 1'b0;
            bus.op_ack    = 1'b0;
            bus.op_commit = 1'b0;
        end
    end

    assign bus.calc_cnt    = cnt_q;
    assign bus.busy        = (state_q != StIdle);
    assign bus.err_timeout = err_q;
    assign bus.done_cnt    = done_q;

endmodule

// File: tb/tb_dut_ctrl_param.sv
// Bench for dut_ctrl_param: two instances (8-bit, no timeout / 4-bit, timeout 4)
// driven by the same stimulus and compared every cycle with a reference model.
module tb_dut_ctrl_param;

    localparam int PIdle   = 0;
    localparam int PStart  = 1;
    localparam int PCalc   = 2;
    localparam int PFinish = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       val_op;
    logic       commit_ack;
    logic       abort;
    logic       sen;
    logic [7:0] calc_len;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dut_ctrl_param_if #(.CNT_W(8)) bus_a ();
    dut_ctrl_param_if #(.CNT_W(4)) bus_b ();

    assign bus_a.val_op     = val_op;
    assign bus_a.commit_ack = commit_ack;
    assign bus_a.abort      = abort;
    assign bus_a.sen        = sen;
    assign bus_a.calc_len   = calc_len;
    assign bus_b.val_op     = val_op;
    assign bus_b.commit_ack = commit_ack;
    assign bus_b.abort      = abort;
    assign bus_b.sen        = sen;
    assign bus_b.calc_len   = calc_len[3:0];

    dut_ctrl_param #(.CNT_W(8), .DEF_LEN(8), .TIMEOUT(0)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    dut_ctrl_param #(.CNT_W(4), .DEF_LEN(5), .TIMEOUT(4)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    // Reference model: operation phase, elapsed calc cycles, latched length,
    // cycles spent waiting for the commit, committed count, sticky error.
    int m_ph[2];
    int m_cnt[2];
    int m_len[2];
    int m_wt[2];
    int m_done[2];
    bit m_err[2];
    bit m_valid = 1'b0;
    int p_mask[2] = '{255, 15};
    int p_def[2]  = '{8, 5};
    int p_tmo[2]  = '{0, 4};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_eval(input int i, output bit ack, output bit com, output bit en,
                              output bit sel, output bit bsy);
        bit act;
        act = (m_ph[i] != PIdle);
        ack = (m_ph[i] == PStart);
        com = (m_ph[i] == PFinish);
        en  = (m_ph[i] == PStart) || (m_ph[i] == PCalc);
        sel = (m_ph[i] != PCalc);
        bsy = act;
        if (abort && act) begin
            en = 1'b0;
        end else if (sen) begin
            ack = 1'b0;
            com = 1'b0;
            en  = 1'b0;
        end
    endtask

    task automatic model_step(input int i);
        int l;
        if (reset) begin
            m_ph[i] = PIdle; m_cnt[i] = 0; m_len[i] = p_def[i];
            m_wt[i] = 0; m_done[i] = 0; m_err[i] = 1'b0;
        end else if (abort && m_ph[i] != PIdle) begin
            m_ph[i] = PIdle; m_cnt[i] = 0; m_wt[i] = 0;
        end else if (!sen) begin
            case (m_ph[i])
                PIdle: if (val_op) m_ph[i] = PStart;
                PStart: begin
                    l = int'(calc_len) & p_mask[i];
                    m_len[i] = (l == 0) ? p_def[i] : l;
                    m_ph[i] = PCalc;
                end
                PCalc: begin
                    if (m_cnt[i] + 1 == m_len[i]) begin
                        m_cnt[i] = 0; m_wt[i] = 0; m_ph[i] = PFinish;
                    end else begin
                        m_cnt[i]++;
                    end
                end
                default: begin
                    if (commit_ack) begin
                        m_done[i] = (m_done[i] + 1) & p_mask[i];
                        m_ph[i] = PIdle; m_wt[i] = 0;
                    end else if (p_tmo[i] > 0 && m_wt[i] + 1 == p_tmo[i]) begin
                        m_err[i] = 1'b1; m_ph[i] = PIdle; m_wt[i] = 0;
                    end else begin
                        m_wt[i]++;
                    end
                end
            endcase
        end
    endtask

    task automatic check_outputs(input string pfx, input int i, input logic ack,
                                 input logic com, input logic en, input logic sel,
                                 input logic bsy, input logic err, input logic [7:0] cnt,
                                 input logic [7:0] done);
        bit e_ack, e_com, e_en, e_sel, e_bsy;
        model_eval(i, e_ack, e_com, e_en, e_sel, e_bsy);
        chk({pfx, ".op_ack"}, 32'(ack), 32'(e_ack));
        chk({pfx, ".op_commit"}, 32'(com), 32'(e_com));
        chk({pfx, ".reg_en"}, 32'(en), 32'(e_en));
        chk({pfx, ".reg_sel"}, 32'(sel), 32'(e_sel));
        chk({pfx, ".busy"}, 32'(bsy), 32'(e_bsy));
        chk({pfx, ".err_timeout"}, 32'(err), 32'(m_err[i]));
        chk({pfx, ".calc_cnt"}, 32'(cnt), 32'(m_cnt[i]));
        chk({pfx, ".done_cnt"}, 32'(done), 32'(m_done[i]));
    endtask

    // Called just after a falling edge with this cycle's inputs applied.
    task automatic tick();
        #1;
        if (m_valid) begin
            check_outputs("a", 0, bus_a.op_ack, bus_a.op_commit, bus_a.reg_en, bus_a.reg_sel,
                          bus_a.busy, bus_a.err_timeout, 8'(bus_a.calc_cnt),
                          8'(bus_a.done_cnt));
            check_outputs("b", 1, bus_b.op_ack, bus_b.op_commit, bus_b.reg_en, bus_b.reg_sel,
                          bus_b.busy, bus_b.err_timeout, 8'(bus_b.calc_cnt),
                          8'(bus_b.done_cnt));
        end
        model_step(0);
        model_step(1);
        if (reset === 1'b1) m_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        val_op = 1'b0; commit_ack = 1'b0; abort = 1'b0; sen = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    // One operation; ack d cycles after op_commit rises on instance a.
    task automatic run_op(input int len, input int d, input bit scramble);
        int len_eff;
        len_eff = (len == 0) ? 8 : len;
        calc_len = 8'(len);
        for (int c = 0; c <= len_eff + 2 + d; c++) begin
            val_op = (c == 0);
            commit_ack = (c == len_eff + 2 + d);
            if (scramble && c >= 2) calc_len = 8'($urandom_range(0, 255));
            tick();
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        reset = 1'b1;
        calc_len = 8'd0;
        idle_inputs();
        @(negedge clk);
        tick();
        reset = 1'b0;
        tick();
        chk("reset.busy", 32'(bus_a.busy), 32'd0);
        chk("reset.reg_sel", 32'(bus_a.reg_sel), 32'd1);

        // Basic op with default length; instance b times out before the late ack.
        run_op(0, 2, 1'b0);
        chk("basic.done_a", 32'(bus_a.done_cnt), 32'd1);
        chk("basic.busy_a", 32'(bus_a.busy), 32'd0);
        chk("basic.err_b", 32'(bus_b.err_timeout), 32'd1);

        // Runtime lengths, including changes to calc_len while calculating
        do_reset();
        run_op(3, 0, 1'b0);
        run_op(1, 1, 1'b0);
        run_op(4, 1, 1'b1);
        run_op(2, 0, 1'b1);
        chk("len.done_a", 32'(bus_a.done_cnt), 32'd4);

        // Scan freeze in CALC at calc_cnt=4
        calc_len = 8'd8;
        for (int c = 0; c <= 15; c++) begin
            val_op = (c == 0);
            sen = (c >= 6 && c <= 10);
            commit_ack = (c == 15);
            if (c == 8) begin
                #1;
                chk("sen.calc_cnt", 32'(bus_a.calc_cnt), 32'd4);
                chk("sen.reg_en", 32'(bus_a.reg_en), 32'd0);
                chk("sen.busy", 32'(bus_b.busy), 32'd1);
            end
            if (c == 11) begin
                #1;
                chk("sen.resume_cnt", 32'(bus_a.calc_cnt), 32'd4);
                chk("sen.resume_en", 32'(bus_a.reg_en), 32'd1);
            end
            tick();
        end
        idle_inputs();
        tick();

        // Scan enable during START delays op_ack
        calc_len = 8'd1;
        for (int c = 0; c <= 6; c++) begin
            val_op = (c == 0);
            sen = (c >= 1 && c <= 3);
            commit_ack = (c == 6);
            if (c == 4) begin
                #1;
                chk("sen.late_ack", 32'(bus_a.op_ack), 32'd1);
            end
            tick();
        end
        idle_inputs();
        tick();

        // Abort at calc_cnt=2, then abort together with sen
        do_reset();
        calc_len = 8'd5;
        for (int c = 0; c <= 11; c++) begin
            val_op = (c == 0 || c == 6);
            abort = (c == 4 || c == 9);
            sen = (c == 9);
            if (c == 5 || c == 10) begin
                #1;
                chk("abort.busy", 32'(bus_a.busy), 32'd0);
                chk("abort.calc_cnt", 32'(bus_b.calc_cnt), 32'd0);
            end
            tick();
        end
        idle_inputs();
        chk("abort.done_a", 32'(bus_a.done_cnt), 32'd0);

        // Commit timeout on instance b, no ack
        do_reset();
        calc_len = 8'd2;
        for (int c = 0; c <= 11; c++) begin
            val_op = (c == 0);
            if (c == 8) begin
                #1;
                chk("tmo.err_b", 32'(bus_b.err_timeout), 32'd1);
                chk("tmo.busy_b", 32'(bus_b.busy), 32'd0);
                chk("tmo.done_b", 32'(bus_b.done_cnt), 32'd0);
                chk("tmo.busy_a", 32'(bus_a.busy), 32'd1);
            end
            tick();
        end
        commit_ack = 1'b1;
        tick();
        idle_inputs();
        tick();
        chk("tmo.sticky", 32'(bus_b.err_timeout), 32'd1);

        // Ack on the final timeout cycle commits without error
        do_reset();
        run_op(2, 3, 1'b0);
        chk("tmo.ack_err", 32'(bus_b.err_timeout), 32'd0);
        chk("tmo.ack_done", 32'(bus_b.done_cnt), 32'd1);

        // done_cnt wrap on the 4-bit instance, then reset mid-operation
        do_reset();
        for (int k = 0; k < 16; k++) run_op(1, 0, 1'b0);
        chk("wrap.done_b", 32'(bus_b.done_cnt), 32'd0);
        chk("wrap.done_a", 32'(bus_a.done_cnt), 32'd16);
        calc_len = 8'd3;
        for (int c = 0; c <= 4; c++) begin
            val_op = (c == 0);
            reset = (c == 3);
            tick();
        end
        reset = 1'b0;
        idle_inputs();
        chk("wrap.rst_busy", 32'(bus_b.busy), 32'd0);
        chk("wrap.rst_done", 32'(bus_a.done_cnt), 32'd0);

        // Random traffic
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            val_op = ($urandom_range(0, 1) == 1);
            commit_ack = ($urandom_range(0, 9) < 3);
            abort = ($urandom_range(0, 19) == 0);
            sen = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 99) == 0);
            calc_len = 8'($urandom_range(0, 12));
            tick();
        end
        reset = 1'b0;
        idle_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
